// File: rtl/trans_chroma_pipe.sv
// trans_chroma_pipe: 6-stage luma-gated nonlinear chroma transform over NCH channels with valid/ready and an external sync LUT.
// Define TRANS_SAT_EN to clamp the transformed sum to [0, 255<<FRAC].
module trans_chroma_pipe #(
  parameter int NCH    = 2,
  parameter int FP_W   = 20,
  parameter int FRAC   = 8,
  parameter int K_L    = 125,
  parameter int K_H    = 188,
  parameter int CENTER = 27904
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            y_in,
  input  logic [8*NCH-1:0]      c_in,
  output logic [7:0]            lut_y,
  output logic                  lut_rd_en,
  input  logic [FP_W*NCH-1:0]   lut_mean,
  input  logic [FP_W*NCH-1:0]   lut_width,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FP_W*NCH-1:0]   out_data
);
  localparam int CW = 8*NCH;
  localparam logic signed [FP_W-1:0] SMAX = FP_W'(255 << FRAC);
  logic stall;
  logic [CW-1:0] c0_q, c0_d, c1_q, c1_d, c2_q, c2_d, c3_q, c3_d, c4_q, c4_d;
  logic [7:0] lut_y_q, lut_y_d;
  logic [5:0] v_q, v_d;
  logic [4:0] p_q, p_d;
  logic [NCH-1:0][FP_W-1:0] diff_q, diff_d, w_q, w_d, prod_q, prod_d, sum_q, sum_d, out_q, out_d;
  logic signed [2*FP_W-1:0] full;
  logic signed [FP_W-1:0] sat;
  assign stall     = v_q[5] & ~out_ready;
  assign in_ready  = ~stall;
  assign lut_rd_en = ~stall;
  assign lut_y     = lut_y_q;
  assign out_valid = v_q[5];
  assign out_data  = out_q;
  // The LUT output seen while a pixel sits in S1 belongs to it, so S2 consumes it directly.
  always_comb begin
    c0_d = c0_q; c1_d = c1_q; c2_d = c2_q; c3_d = c3_q; c4_d = c4_q;
    lut_y_d = lut_y_q; v_d = v_q; p_d = p_q;
    diff_d = diff_q; w_d = w_q; prod_d = prod_q; sum_d = sum_q; out_d = out_q;
    full = '0;
    sat = '0;
    if (!stall) begin
      v_d = {v_q[4:0], in_valid};
      p_d = {p_q[3:0], (32'(y_in) >= K_L) && (32'(y_in) <= K_H)};
      c0_d = c_in; c1_d = c0_q; c2_d = c1_q; c3_d = c2_q; c4_d = c3_q;
      lut_y_d = y_in;
      for (int i = 0; i < NCH; i++) begin
        diff_d[i] = {{(FP_W-8-FRAC){1'b0}}, c1_q[8*i+:8], {FRAC{1'b0}}} - lut_mean[FP_W*i+:FP_W];
        w_d[i] = lut_width[FP_W*i+:FP_W];
        full = $signed(diff_q[i]) * $signed(w_q[i]);
        prod_d[i] = FP_W'(full >>> FRAC);
        sum_d[i] = prod_q[i] + FP_W'(CENTER);
`ifdef TRANS_SAT_EN
        sat = $signed(sum_q[i]) < 0 ? '0 : ($signed(sum_q[i]) > SMAX ? SMAX : $signed(sum_q[i]));
`else
        sat = $signed(sum_q[i]);
`endif
        out_d[i] = p_q[4] ? {{(FP_W-8-FRAC){1'b0}}, c4_q[8*i+:8], {FRAC{1'b0}}} : sat;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c0_q <= '0; c1_q <= '0; c2_q <= '0; c3_q <= '0; c4_q <= '0;
      lut_y_q <= '0; v_q <= '0; p_q <= '0;
      diff_q <= '0; w_q <= '0; prod_q <= '0; sum_q <= '0; out_q <= '0;
    end else begin
      c0_q <= c0_d; c1_q <= c1_d; c2_q <= c2_d; c3_q <= c3_d; c4_q <= c4_d;
      lut_y_q <= lut_y_d; v_q <= v_d; p_q <= p_d;
      diff_q <= diff_d; w_q <= w_d; prod_q <= prod_d; sum_q <= sum_d; out_q <= out_d;
    end
  end
endmodule

// File: tb/tb_trans_chroma_pipe.sv
// tb_trans_chroma_pipe: randomized valid/ready bench with a queue-based arithmetic reference model and a synchronous LUT model.
module tb_trans_chroma_pipe;
  localparam int NCH = 2;
  localparam int W = 20;
  localparam int CW = 8*NCH;
  localparam int DW = W*NCH;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic in_ready, lut_rd_en, out_valid;
  logic [7:0] y_in = 0, lut_y;
  logic [CW-1:0] c_in = 0;
  logic [DW-1:0] lm, lw, out_data;
  logic [DW-1:0] mean_t [256];
  logic [DW-1:0] width_t [256];
  logic [DW-1:0] exp_q [$];
  int checks = 0, errors = 0;
  logic prev_stall = 0;
  logic [7:0] prev_lut_y = 0;

  trans_chroma_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .y_in(y_in), .c_in(c_in), .lut_y(lut_y), .lut_rd_en(lut_rd_en),
    .lut_mean(lm), .lut_width(lw), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (lut_rd_en) begin
    lm <= mean_t[lut_y];
    lw <= width_t[lut_y];
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic longint wrap(longint v);
    longint r;
    r = v & 64'hFFFFF;
    if (r >= 64'h80000) r = r - 64'h100000;
    return r;
  endfunction

  function automatic logic [W-1:0] ref_ch(int y, int c, logic [W-1:0] m, logic [W-1:0] w);
    longint d, p, s;
    if (y >= 125 && y <= 188) return W'(c * 256);
    d = wrap(longint'(c * 256) - longint'($signed(m)));
    p = wrap((d * longint'($signed(w))) >>> 8);
    s = wrap(p + 27904);
`ifdef TRANS_SAT_EN
    if (s < 0) s = 0;
    if (s > 65280) s = 65280;
`endif
    return W'(s);
  endfunction

  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (!rst_n) prev_stall = 0;
    else begin
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      chk("lut_rd_en", lut_rd_en, !(out_valid && !out_ready));
      if (prev_stall) chk("lut_y_hold", lut_y, prev_lut_y);
      if (in_valid && in_ready) begin
        for (int i = 0; i < NCH; i++)
          e[W*i+:W] = ref_ch(y_in, c_in[8*i+:8], mean_t[y_in][W*i+:W], width_t[y_in][W*i+:W]);
        exp_q.push_back(e);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", 1, 0);
        else chk("out_data", out_data, exp_q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_lut_y = lut_y;
    end
  end

  task automatic one(input int y, input int c0, input int m0, input int w0, input int exp0);
    int n;
    mean_t[y] = {W'($urandom), W'(m0)};
    width_t[y] = {W'($urandom_range(0, 1023)), W'(w0)};
    y_in = 8'(y);
    c_in = {8'($urandom), 8'(c0)};
    in_valid = 1;
    out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    for (n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (out_valid) break;
    end
    chk("latency", 64'(n), 5);
    chk("data0", 64'($signed(out_data[W-1:0])), 64'(exp0));
    @(posedge clk); #1;
  endtask

  task automatic drain(string name);
    in_valid = 0;
    out_ready = 1;
    repeat (12) @(posedge clk);
    #1;
    chk(name, 64'(exp_q.size()), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mean_t[i] = '0;
      width_t[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_lut_y", lut_y, 0);
    rst_n = 1;
    @(posedge clk); #1;
    one(200, 120, 27648, 384, 32512);
    one(150, 120, 1234, 777, 30720);
    one(125, 77, 27648, 384, 19712);
    one(188, 77, 27648, 384, 19712);
    one(124, 120, 27648, 384, 32512);
    one(189, 120, 27648, 384, 32512);
`ifdef TRANS_SAT_EN
    one(200, 255, 0, 1024, 65280);
    one(200, 0, 51200, 1024, 0);
`else
    one(200, 255, 0, 1024, 289024);
    one(200, 0, 51200, 1024, -176896);
`endif
    for (int i = 0; i < 256; i++) begin
      mean_t[i] = DW'({$urandom, $urandom});
      width_t[i] = DW'({$urandom, $urandom});
    end
    in_valid = 1;
    for (int k = 0; k < 24; k++) begin
      y_in = 8'($urandom);
      c_in = CW'($urandom);
      out_ready = (k % 4 == 0) || (k % 4 == 3);
      @(posedge clk); #1;
    end
    drain("stall_drain");
    in_valid = 1;
    for (int k = 0; k < 3; k++) begin
      y_in = 8'($urandom);
      c_in = CW'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_lut_y", lut_y, 0);
    exp_q.delete();
    @(posedge clk); #3 rst_n = 1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("post_rst_idle", out_valid, 0);
    end
    for (int k = 0; k < 800; k++) begin
      in_valid = ($urandom % 10) < 7;
      out_ready = ($urandom % 10) < 7;
      case ($urandom % 8)
        0: y_in = 124;
        1: y_in = 125;
        2: y_in = 188;
        3: y_in = 189;
        default: y_in = 8'($urandom);
      endcase
      c_in = CW'($urandom);
      @(posedge clk); #1;
    end
    drain("random_drain");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/trans_chroma_pipe.md
Name: trans_chroma_pipe

Overview:
- Parametrised successor to the single-channel skin-tone chroma transform.
- Applies the luma-dependent nonlinear chroma transform to NCH chroma channels (default Cb and Cr) sharing one Y, in a fully pipelined datapath.
- Adds valid/ready flow control, an external synchronous mean/width LUT interface, and parametrised fixed-point width and luma thresholds.
- Sits between the YCbCr converter and the skin classifier.

Parameters:
- NCH, 2: number of chroma channels; channel i is bits [8i+7:8i].
- FP_W, 20: signed fixed-point width of datapath and outputs.
- FRAC, 8: fractional bits.
- K_L, 125: lower luma pass-through threshold, inclusive.
- K_H, 188: upper luma pass-through threshold, inclusive.
- CENTER, 27904: fixed-point centre added after scaling (109.0).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  input accepted when in_valid and in_ready are both high.
- y_in  in  8  luma.
- c_in  in  8*NCH  chroma channels.
- lut_y  out  8  LUT address (registered accepted Y).
- lut_rd_en  out  1  LUT read enable.
- lut_mean  in  FP_W*NCH  signed per-channel mean; valid the cycle after a read is issued.
- lut_width  in  FP_W*NCH  signed per-channel width scale, same timing as lut_mean.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream ready.
- out_data  out  FP_W*NCH  signed transformed chroma, fixed point.

Behaviour:
- Reset (async, rst_n=0): every stage valid bit clears; out_valid=0; out_data=0; lut_y=0.
  - Reset mid-stream discards all in-flight pixels; nothing partial emerges after release.
- Stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - lut_rd_en = ~stall.
  - During a stall every pipeline register, including lut_y, holds its value.
  - The LUT must hold its output while lut_rd_en=0.
- Stages; each advances only when not stalled, and a valid bit travels with every stage.
  - S0: register C, Y and in_valid. lut_y = Y0. pass0 = (K_L <= y_in <= K_H), computed from the accepted y_in.
  - S1: capture lut_mean and lut_width; forward C and pass.
  - S2: diff_i = zero-extended {C_i, FRAC zeros} - mean_i, signed FP_W.
  - S3: prod_i = (diff_i * width_i), full 2*FP_W product, arithmetic shift right FRAC (floor), truncated to FP_W.
  - S4: sum_i = prod_i + CENTER, FP_W wrap.
  - S5 (output register): out_data_i = pass ? {C_i, FRAC zeros} : sum_i. out_valid = stage valid.
- Latency: exactly 5 cycles from acceptance to out_valid when there is no back-pressure. Throughput is 1 pixel/cycle.
- Bubbles: in_valid=0 inserts an invalid slot. out_data need not change on an invalid slot, but out_valid must be 0 for it.
- Simultaneous out_ready falling while in_valid is high: that pixel is not accepted (in_ready is low that cycle). No pixel is dropped or duplicated.
- Channels are independent. Pass-through is decided per pixel and applies to all channels.

Optional Feature:
- TRANS_SAT_EN defined: sum_i is clamped to [0, 255<<FRAC] before the output mux. Pass-through values are unaffected.
- TRANS_SAT_EN undefined: sum_i wraps in FP_W two's complement; no clamp.

Test Plan:
- Y=200, C0=120, mean0=27648, width0=384 (1.5), no stall -> out_valid 5 cycles after acceptance; out_data0=32512 (127.0).
- Y=150 (inside [125,188]), C0=120 -> out_data0=30720 regardless of LUT data.
- Y=125 and Y=188 -> pass-through; Y=124 and Y=189 -> transformed.
- Y=200, C0=255, mean0=0, width0=1024 -> out_data0=65280 with TRANS_SAT_EN, 289024 without.
- Y=200, C0=0, mean0=51200, width0=1024 -> 0 with TRANS_SAT_EN, -176896 without.
- Continuous in_valid with out_ready toggling 1,0,0,1 -> in_ready follows ~stall; output order preserved; no loss or duplication; lut_y held during the stall.
- rst_n pulsed low mid-stream with 3 pixels in flight -> out_valid=0 immediately; no stale pixel emerges after release.
